// File: rtl/arb_pkg.sv
// Shared types and helpers for the cacheline arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    // Width of an index covering n items; never narrower than one bit.
    function automatic int port_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: round-robin after the last grant, or
// fixed priority (lowest index) with starved ports served first.
module arb_pick
    import arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int MODE      = MODE_RR
) (
    input  logic [NUM_PORTS-1:0]             req_i,
    input  logic [port_idx_w(NUM_PORTS)-1:0] last_i,
    input  logic [NUM_PORTS-1:0]             starved_i,
    output logic [port_idx_w(NUM_PORTS)-1:0] win_idx_o,
    output logic                             win_vld_o
);

    localparam int IW = port_idx_w(NUM_PORTS);

    logic [NUM_PORTS-1:0] cand;
    logic [IW-1:0]        p;

    // Scan in reverse search order so the first candidate in order is the last one written.
    always_comb begin
        win_idx_o = '0;
        win_vld_o = |req_i;
        cand      = req_i & starved_i;
        p         = '0;
        if (MODE == MODE_RR) begin
            for (int k = NUM_PORTS; k >= 1; k--) begin
                p = IW'((int'(last_i) + k) % NUM_PORTS);
                if (req_i[p]) win_idx_o = p;
            end
        end else begin
            if (cand == '0) cand = req_i;
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (cand[IW'(i)]) win_idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port cacheline arbiter feeding one downstream line port. One grant
// covers one atomic read or write; a dead cycle follows each completion so
// a client's held request is never re-granted after its response.
module mem_arbiter_rr
    import arb_pkg::*;
#(
    parameter int NUM_PORTS    = 2,
    parameter int LINE_WIDTH   = 256,
    parameter int ADDR_WIDTH   = 32,
    parameter int MODE         = MODE_RR,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [NUM_PORTS-1:0]                 cli_read,
    input  logic [NUM_PORTS-1:0]                 cli_write,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] cli_addr,
    input  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0] cli_wdata,
    output logic [NUM_PORTS-1:0]                 cli_resp,
    output logic [LINE_WIDTH-1:0]                cli_rdata,
    output logic                                 dn_read,
    output logic                                 dn_write,
    output logic [ADDR_WIDTH-1:0]                dn_addr,
    output logic [LINE_WIDTH-1:0]                dn_wdata,
    input  logic                                 dn_resp,
    input  logic [LINE_WIDTH-1:0]                dn_rdata,
    output logic                                 grant_valid,
    output logic [port_idx_w(NUM_PORTS)-1:0]     grant_idx
);

    localparam int            IW  = port_idx_w(NUM_PORTS);
    localparam int            CW  = port_idx_w(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CAP = CW'(STARVE_LIMIT);

    arb_state_e                   state_q, state_d;
    logic [IW-1:0]                last_q, last_d;
    logic [IW-1:0]                gidx_q, gidx_d;
    logic                         wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
    logic [LINE_WIDTH-1:0]        wdata_q, wdata_d;
    logic [NUM_PORTS-1:0][CW-1:0] cnt_q, cnt_d;

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] starved;
    logic [IW-1:0]        win_idx;
    logic                 win_vld;

    assign req = cli_read | cli_write;

    // A port is starved once its lost-arbitration count reaches the cap; cap 0 means never.
    always_comb begin
        starved = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            starved[IW'(i)] = (STARVE_LIMIT != 0) && (cnt_q[IW'(i)] == CAP);
        end
    end

    arb_pick #(
        .NUM_PORTS (NUM_PORTS),
        .MODE      (MODE)
    ) u_pick (
        .req_i     (req),
        .last_i    (last_q),
        .starved_i (starved),
        .win_idx_o (win_idx),
        .win_vld_o (win_vld)
    );

    // Next state: latch the winner's op/addr/data in IDLE, wait for dn_resp, then one dead cycle.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gidx_d  = gidx_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = ISSUE;
                    last_d  = win_idx;
                    gidx_d  = win_idx;
                    wr_d    = cli_write[win_idx];
                    addr_d  = cli_addr[win_idx];
                    wdata_d = cli_wdata[win_idx];
                    if (MODE == MODE_FIXED) begin
                        for (int i = 0; i < NUM_PORTS; i++) begin
                            if (!req[IW'(i)] || (IW'(i) == win_idx)) cnt_d[IW'(i)] = '0;
                            else if (cnt_q[IW'(i)] != CAP)           cnt_d[IW'(i)] = cnt_q[IW'(i)] + 1'b1;
                        end
                    end
                end
            end
            ISSUE:   if (dn_resp) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and transaction registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= IW'(NUM_PORTS - 1);
            gidx_q  <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gidx_q  <= gidx_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Completion pulse to the granted port, combinational with dn_resp in ISSUE.
    always_comb begin
        cli_resp = '0;
        if ((state_q == ISSUE) && dn_resp) cli_resp[gidx_q] = 1'b1;
    end

    assign dn_read     = (state_q == ISSUE) && !wr_q;
    assign dn_write    = (state_q == ISSUE) && wr_q;
    assign dn_addr     = addr_q;
    assign dn_wdata    = wdata_q;
    assign cli_rdata   = dn_rdata;
    assign grant_valid = (state_q == ISSUE);
    assign grant_idx   = gidx_q;

    // Read and write together on one port is a client bug; hardware treats it as a write.
    a_rw_excl: assert property (@(posedge clk) disable iff (!reset_n) (cli_read & cli_write) == '0);

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench: 4-port round-robin instance checked cycle by cycle against a
// transaction-level model, plus two 2-port fixed-priority instances
// (starve cap 2 and 0) checked against hand-computed grant sequences.
module tb_mem_arbiter_rr;

    localparam int LW = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- instance A: 4 ports, round-robin
    logic [3:0]          a_read, a_write, a_resp;
    logic [3:0][31:0]    a_addr;
    logic [3:0][LW-1:0]  a_wdata;
    logic [LW-1:0]       a_crd, a_dwd, a_drd;
    logic                a_dr, a_dw, a_dresp, a_gv;
    logic [31:0]         a_daddr;
    logic [1:0]          a_gidx;

    mem_arbiter_rr #(.NUM_PORTS(4), .LINE_WIDTH(LW), .ADDR_WIDTH(32), .MODE(0), .STARVE_LIMIT(4)) dut_a (
        .clk(clk), .reset_n(rst_n), .cli_read(a_read), .cli_write(a_write), .cli_addr(a_addr),
        .cli_wdata(a_wdata), .cli_resp(a_resp), .cli_rdata(a_crd), .dn_read(a_dr), .dn_write(a_dw),
        .dn_addr(a_daddr), .dn_wdata(a_dwd), .dn_resp(a_dresp), .dn_rdata(a_drd),
        .grant_valid(a_gv), .grant_idx(a_gidx));

    // ---------------- instances B (cap 2) and C (cap 0): 2 ports, fixed priority
    logic [1:0]         bc_read, bc_write;
    logic [1:0][31:0]   bc_addr;
    logic [1:0][LW-1:0] bc_wdata;
    logic [LW-1:0]      bc_drd;
    logic [1:0]         b_resp, c_resp;
    logic [LW-1:0]      b_crd, c_crd, b_dwd, c_dwd;
    logic               b_dr, b_dw, b_gv, c_dr, c_dw, c_gv;
    logic               b_dresp = 1'b0, c_dresp = 1'b0;
    logic [31:0]        b_daddr, c_daddr;
    logic [0:0]         b_gidx, c_gidx;

    mem_arbiter_rr #(.NUM_PORTS(2), .LINE_WIDTH(LW), .ADDR_WIDTH(32), .MODE(1), .STARVE_LIMIT(2)) dut_b (
        .clk(clk), .reset_n(rst_n), .cli_read(bc_read), .cli_write(bc_write), .cli_addr(bc_addr),
        .cli_wdata(bc_wdata), .cli_resp(b_resp), .cli_rdata(b_crd), .dn_read(b_dr), .dn_write(b_dw),
        .dn_addr(b_daddr), .dn_wdata(b_dwd), .dn_resp(b_dresp), .dn_rdata(bc_drd),
        .grant_valid(b_gv), .grant_idx(b_gidx));

    mem_arbiter_rr #(.NUM_PORTS(2), .LINE_WIDTH(LW), .ADDR_WIDTH(32), .MODE(1), .STARVE_LIMIT(0)) dut_c (
        .clk(clk), .reset_n(rst_n), .cli_read(bc_read), .cli_write(bc_write), .cli_addr(bc_addr),
        .cli_wdata(bc_wdata), .cli_resp(c_resp), .cli_rdata(c_crd), .dn_read(c_dr), .dn_write(c_dw),
        .dn_addr(c_daddr), .dn_wdata(c_dwd), .dn_resp(c_dresp), .dn_rdata(bc_drd),
        .grant_valid(c_gv), .grant_idx(c_gidx));

    // Downstream for B and C answers in the same cycle it sees a strobe.
    initial forever begin @(posedge clk); #2; b_dresp = b_dr | b_dw; end
    initial forever begin @(posedge clk); #2; c_dresp = c_dr | c_dw; end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model of instance A
    bit          m_busy = 0, m_cool = 0, m_wr = 0;
    int          m_own = 0, m_last = 3;
    logic [31:0] m_addr = '0;
    logic [LW-1:0] m_wd = '0;
    int          mlog[$], dlog[$], blog[$], clog[$];

    always @(posedge clk) begin
        int p;
        bit found;
        found = 0;
        if (!rst_n) begin
            m_busy = 0; m_cool = 0; m_last = 3;
        end else if (m_cool) begin
            m_cool = 0;
        end else if (m_busy) begin
            if (a_dresp) begin m_busy = 0; m_cool = 1; end
        end else begin
            for (int k = 1; k <= 4; k++) begin
                p = (m_last + k) % 4;
                if (!found && (a_read[p] || a_write[p])) begin
                    found = 1;
                    m_busy = 1; m_own = p; m_last = p;
                    m_wr = a_write[p]; m_addr = a_addr[p]; m_wd = a_wdata[p];
                    mlog.push_back(p);
                end
            end
        end
    end

    // Compare process: A against the model every cycle; grant logs for all instances.
    logic a_gvp = 0, b_gvp = 0, c_gvp = 0;
    always @(negedge clk) begin
        logic [3:0] er;
        er = (m_busy && a_dresp) ? (4'b0001 << m_own) : 4'b0000;
        chk("a_ctl", {a_gv, a_dr, a_dw, a_resp}, {m_busy, m_busy && !m_wr, m_busy && m_wr, er});
        chk("a_rdata_bcast", a_crd, a_drd);
        if (m_busy) begin
            chk("a_grant_addr", {a_gidx, a_daddr}, {m_own[1:0], m_addr});
            chk("a_wdata", a_dwd, m_wd);
        end
        if (a_gv && !a_gvp) dlog.push_back(int'(a_gidx));
        if (b_gv && !b_gvp && blog.size() < 6) blog.push_back(int'(b_gidx));
        if (c_gv && !c_gvp && clog.size() < 6) clog.push_back(int'(c_gidx));
        a_gvp = a_gv; b_gvp = b_gv; c_gvp = c_gv;
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic wait_strobe();
        int n;
        n = 0;
        while (!(a_dr || a_dw) && n < 20) begin step(); n++; end
        checks++;
        if (!(a_dr || a_dw)) begin
            failures++;
            $display("FAIL strobe_timeout actual=0 required=1 @%0t", $time);
        end
    endtask

    task automatic respond(input int lat, input logic [LW-1:0] rd);
        repeat (lat) step();
        a_dresp = 1'b1; a_drd = rd;
        step();
        a_dresp = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    int expA[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    int expB[6] = '{0, 0, 1, 0, 0, 1};

    initial begin
        rst_n = 1'b0;
        a_read = 4'hF; a_write = '0; a_dresp = 1'b0; a_drd = '0;
        for (int p = 0; p < 4; p++) begin
            a_addr[p]  = 32'h1000_0000 + 32'(p * 64);
            a_wdata[p] = 64'hA5A5_0000_0000_0000 + 64'(p);
        end
        bc_read = 2'b11; bc_write = '0; bc_drd = 64'h0123_4567_89AB_CDEF;
        bc_addr[0] = 32'h0000_0100; bc_addr[1] = 32'h0000_0200;
        bc_wdata[0] = '0; bc_wdata[1] = '0;

        // Reset held two cycles with every request high.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {a_dr, a_dw, a_gv, a_resp, a_gidx, a_daddr}, '0);
        chk("rst_wdata", a_dwd, '0);
        chk("rst_bc", {b_dr, b_gv, b_resp, c_dr, c_gv, c_resp}, '0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first_grant_a", {a_dr, a_gidx}, {1'b1, 2'd0});
        chk("first_grant_bc", {b_dr, b_gidx, c_dr, c_gidx}, 4'b1010);
        #1;

        // Round-robin, all four requesting: 0,1,2,3,0.
        repeat (5) begin
            wait_strobe();
            respond(0, 64'h1111_2222_3333_4444);
        end
        a_read = '0;

        // Single read from port 1, answered after 5 cycles.
        step();
        a_addr[1] = 32'h0000_1A40; a_read = 4'b0010;
        wait_strobe();
        chk("sr_addr", {a_gidx, a_daddr}, {2'd1, 32'h0000_1A40});
        repeat (5) step();
        a_dresp = 1'b1; a_drd = 64'hDEAD_BEEF_DEAD_BEEF;
        #1;
        chk("sr_resp", a_resp, 4'b0010);
        chk("sr_rdata", a_crd, 64'hDEAD_BEEF_DEAD_BEEF);
        step();
        a_dresp = 1'b0; a_read = '0;
        #1 chk("sr_done", {a_gv, a_dr, a_resp}, '0);
        #1;

        // Write from port 2.
        a_addr[2] = 32'h0000_2000; a_wdata[2] = 64'hFEED_F00D_CAFE_0002; a_write = 4'b0100;
        wait_strobe();
        chk("wr_op", {a_dw, a_dr, a_dwd}, {1'b1, 1'b0, 64'hFEED_F00D_CAFE_0002});
        respond(2, 64'h0);
        a_write = '0;

        // Reset in the middle of a read from port 3.
        step();
        a_read = 4'b1000;
        wait_strobe();
        step();
        rst_n = 1'b0; a_read = '0;
        @(posedge clk); #1;
        chk("mr_drop", {a_dr, a_dw, a_gv, a_resp}, '0);
        #1 a_dresp = 1'b1;
        #1 chk("mr_noresp", a_resp, '0);
        step();
        a_dresp = 1'b0; rst_n = 1'b1;
        step();

        // Address change after grant must not reach downstream.
        a_addr[0] = 32'h0000_3300; a_read = 4'b0001;
        wait_strobe();
        a_addr[0] = 32'hFFFF_0000;
        step();
        chk("stale_addr", a_daddr, 32'h0000_3300);
        respond(1, 64'h5555_AAAA_5555_AAAA);
        a_read = '0;
        step(); step();

        // dn_resp while idle is ignored.
        a_dresp = 1'b1;
        #1 chk("idle_resp", {a_resp, a_gv}, '0);
        step();
        a_dresp = 1'b0;
        #1 chk("idle_after", {a_gv, a_dr, a_dw}, '0);
        step(); step();

        // Grant sequences.
        chk("a_model_len", mlog.size(), 9);
        chk("a_dut_len", dlog.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < mlog.size()) chk("a_model_seq", mlog[i], expA[i]);
            if (i < dlog.size()) chk("a_dut_seq", dlog[i], expA[i]);
        end
        chk("b_len", blog.size(), 6);
        chk("c_len", clog.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < blog.size()) chk("b_starve_seq", blog[i], expB[i]);
            if (i < clog.size()) chk("c_prio_seq", clog[i], 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
Parametrised N-port cacheline arbiter between L1-side clients (icache, dcache write buffer, prefetcher) and a single downstream line port (L2 or cacheline adaptor). It generalises the fixed two-port arbiter:
- selectable round-robin or fixed-priority arbitration;
- starvation cap in fixed-priority mode;
- configurable line/address width and port count.

Each transaction is atomic: one grant covers exactly one read or write until the downstream responds.

Parameters:
NUM_PORTS, 2, number of client ports (2..8)
LINE_WIDTH, 256, cacheline width in bits
ADDR_WIDTH, 32, address width
MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 highest)
STARVE_LIMIT, 4, fixed-priority only: consecutive lost arbitrations before forced grant; 0 disables

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
cli_read  in  NUM_PORTS  per-port read request, held until cli_resp
cli_write  in  NUM_PORTS  per-port write request, held until cli_resp
cli_addr  in  NUM_PORTS*ADDR_WIDTH  packed per-port line address
cli_wdata  in  NUM_PORTS*LINE_WIDTH  packed per-port write line
cli_resp  out  NUM_PORTS  one-hot completion pulse
cli_rdata  out  LINE_WIDTH  downstream read line, broadcast to all ports
dn_read  out  1  downstream read
dn_write  out  1  downstream write
dn_addr  out  ADDR_WIDTH  downstream address
dn_wdata  out  LINE_WIDTH  downstream write line
dn_resp  in  1  downstream completion
dn_rdata  in  LINE_WIDTH  downstream read line
grant_valid  out  1  transaction in flight (debug/perf)
grant_idx  out  $clog2(NUM_PORTS)  granted port (debug/perf)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (reset_n sampled on the clk rising edge).
- Reset values (reset_n=0 at an edge):
  - state=IDLE;
  - dn_read, dn_write, cli_resp, grant_valid = 0;
  - dn_addr, dn_wdata, grant_idx = 0;
  - RR pointer last=NUM_PORTS-1, so port 0 wins first;
  - all starvation counters = 0.
- Reset mid-transaction: state returns to IDLE and dn_read/dn_write drop at that edge. The in-flight transaction is abandoned. No cli_resp is issued for it.
- FSM:
  - IDLE: if any cli_read|cli_write is set, pick a winner, register its addr/wdata/op and grant_idx, and go to ISSUE. dn_resp is ignored in IDLE.
  - ISSUE: dn_read/dn_write driven from registered op; dn_addr/dn_wdata stable. On dn_resp=1: cli_resp[grant_idx]=1 combinationally in that cycle, cli_rdata=dn_rdata, then go to DONE.
  - DONE: one dead cycle; all outputs deasserted. Lets the client drop its request so a stale request is never re-granted. Then go to IDLE.
- Latency: request seen in cycle 0 -> dn_read/dn_write high in cycle 1. Back-to-back grants are at minimum 3 cycles apart when downstream responds in one cycle.
- grant_valid=1 in ISSUE only.
- Client requests are sampled only in IDLE. Changes to a client's addr/wdata after grant are ignored.
- cli_read and cli_write both set on the same port: treated as a write. A simulation-only assertion fires.
- Round-robin (MODE=0):
  - search ports last+1 .. last+NUM_PORTS modulo NUM_PORTS, first requester wins;
  - last updated to the winner on entry to ISSUE;
  - pointer wraps from NUM_PORTS-1 to 0.
- Fixed priority (MODE=1):
  - the lowest-index requester wins, unless a starved port exists;
  - a port is starved when its counter == STARVE_LIMIT; the lowest-index starved port wins first;
  - at each arbitration, every requesting non-winner's counter increments, saturating at STARVE_LIMIT;
  - the winner's counter clears; non-requesting ports' counters clear;
  - with STARVE_LIMIT=0, counters are held at 0 and the scheme is pure priority.
- Single requester: always wins immediately, in either mode.
- cli_rdata is a wire to dn_rdata. Clients qualify it with their own cli_resp bit.

Decomposition:
- Package arb_pkg:
  - arb_state_e {IDLE, ISSUE, DONE};
  - MODE_RR=0, MODE_FIXED=1 constants;
  - function port_idx_w(n) returning $clog2 width, minimum 1.
- One combinational sub-module, arb_pick (params NUM_PORTS, MODE):
  - inputs: request vector, RR pointer, starved vector;
  - outputs: winner index and valid.
- Counters, FSM and muxing stay in mem_arbiter_rr.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with all requests high -> all outputs 0. First grant after release goes to port 0, dn_read high one cycle after IDLE sample.
- Single read: port 1 reads addr 0x0000_1A40; dn_resp after 5 cycles with rdata 0xDEAD...BEEF -> dn_addr=0x1A40. cli_resp=2'b10 for exactly one cycle with matching cli_rdata, then DONE, then IDLE.
- Round-robin (NUM_PORTS=4, MODE=0), all ports requesting continuously -> grant_idx sequence 0,1,2,3,0 (wrap verified). No port is granted twice before the others.
- Fixed priority with starvation (MODE=1, STARVE_LIMIT=2): ports 0 and 1 request continuously -> grants 0,0,1,0,0,1.
- Fixed priority, STARVE_LIMIT=0, same stimulus -> port 0 granted every arbitration.
- Mid-transaction reset and stale data: reset_n=0 in ISSUE -> dn_read drops at that edge, no cli_resp. Separately, change cli_addr in ISSUE -> dn_addr unchanged. dn_resp pulsed in IDLE -> no cli_resp.
